// File: rtl/apb_fifo_pkg.sv
// Shared definitions for the APB FIFO slice: default geometry, register map
// offsets and the status word layout used by the APB readback path.
package apb_fifo_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int AW_DEF     = $clog2(DEPTH_DEF);
  localparam int LWIDTH_DEF = AW_DEF + 1;

  // APB register offsets
  localparam logic [7:0] REG_DATA_OFS = 8'h00;
  localparam logic [7:0] REG_STAT_OFS = 8'h04;

  // Status word bit positions
  localparam int STAT_EMPTY_BIT     = 0;
  localparam int STAT_FULL_BIT      = 1;
  localparam int STAT_OVERFLOW_BIT  = 2;
  localparam int STAT_UNDERFLOW_BIT = 3;
  localparam int STAT_LEVEL_LSB     = 16;

  // Assemble the status word seen by the APB front-end.
  function automatic logic [31:0] pack_status(input logic [LWIDTH_DEF-1:0] level,
                                              input logic full,
                                              input logic empty,
                                              input logic overflow,
                                              input logic underflow);
    logic [31:0] s;
    s                                   = '0;
    s[STAT_EMPTY_BIT]                   = empty;
    s[STAT_FULL_BIT]                    = full;
    s[STAT_OVERFLOW_BIT]                = overflow;
    s[STAT_UNDERFLOW_BIT]               = underflow;
    s[STAT_LEVEL_LSB +: LWIDTH_DEF]     = level;
    return s;
  endfunction

endpackage

// File: rtl/apb_fifo_if.sv
// Strobe/data bundle between the APB register front-end (master) and the
// FIFO core (slave).
interface apb_fifo_if #(
  parameter int DWIDTH = apb_fifo_pkg::DWIDTH_DEF,
  parameter int LWIDTH = apb_fifo_pkg::LWIDTH_DEF
);

  logic              enable;
  logic              ff_clear;
  logic              ff_write;
  logic [DWIDTH-1:0] ff_wdata;
  logic              ff_read;
  logic [DWIDTH-1:0] ff_rdata;
  logic              ff_full;
  logic              ff_empty;
  logic [LWIDTH-1:0] ff_level;
  logic              ff_overflow;
  logic              ff_underflow;

  modport master (
    output enable, ff_clear, ff_write, ff_wdata, ff_read,
    input  ff_rdata, ff_full, ff_empty, ff_level, ff_overflow, ff_underflow
  );

  modport slave (
    input  enable, ff_clear, ff_write, ff_wdata, ff_read,
    output ff_rdata, ff_full, ff_empty, ff_level, ff_overflow, ff_underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DWIDTH storage: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              pclk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Write port: one word per accepted push.
  // NOTE: the array has no reset -- contents are don't-care until written, and
  // leaving it unreset lets synthesis map it onto RAM; non-blocking keeps the
  // write ordered after every reader sampling this edge.
  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: show-ahead, purely combinational from the read address.
  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_fifo_core.sv
// Single-clock FIFO behind the APB register front-end. Holds pointer, level
// and flag control; storage lives in fifo_ram. The level counter is the
// single source of truth for full/empty.
module apb_fifo_core
  import apb_fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH),
  parameter int LWIDTH = AW + 1
) (
  input  logic pclk,
  input  logic reset_n,
  apb_fifo_if.slave bus
);

  logic [AW-1:0]     wr_ptr,  wr_ptr_nxt;
  logic [AW-1:0]     rd_ptr,  rd_ptr_nxt;
  logic [LWIDTH-1:0] level,   level_nxt;
  logic              full_q,  empty_q;
  logic              ovf_q,   ovf_nxt;
  logic              unf_q,   unf_nxt;
  logic              push_ok, pop_ok;
  logic [DWIDTH-1:0] ram_rdata;

  // Next-state: clear wins, then accept/reject push and pop and track level.
  // NOTE: every signal gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    ovf_nxt    = ovf_q;
    unf_nxt    = unf_q;

    if (bus.enable) begin
      if (bus.ff_clear) begin
        wr_ptr_nxt = '0;
        rd_ptr_nxt = '0;
        level_nxt  = '0;
        ovf_nxt    = 1'b0;
        unf_nxt    = 1'b0;
      end else begin
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = bus.ff_write & (~full_q | bus.ff_read);
        pop_ok  = bus.ff_read & ~empty_q;

        if (push_ok) wr_ptr_nxt = wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr_nxt = rd_ptr + AW'(1);

        unique case ({push_ok, pop_ok})
          2'b10:   level_nxt = level + LWIDTH'(1);
          2'b01:   level_nxt = level - LWIDTH'(1);
          default: level_nxt = level;
        endcase

        if (bus.ff_write && !push_ok) ovf_nxt = 1'b1;
        if (bus.ff_read  && !pop_ok)  unf_nxt = 1'b1;
      end
    end
  end

  // State register; flags are derived from the next level so they are
  // registered alongside it.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      level   <= level_nxt;
      full_q  <= (level_nxt == LWIDTH'(DEPTH));
      empty_q <= (level_nxt == '0);
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  fifo_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .pclk  (pclk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.ff_wdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Head word is masked while empty so stale RAM contents never leak out.
  assign bus.ff_rdata     = empty_q ? '0 : ram_rdata;
  assign bus.ff_full      = full_q;
  assign bus.ff_empty     = empty_q;
  assign bus.ff_level     = level;
  assign bus.ff_overflow  = ovf_q;
  assign bus.ff_underflow = unf_q;

endmodule
